// File: rtl/cond_unit_banked.sv
// Conditional-execution unit with NUM_BANKS banked NZCV flags plus shadow copies.
// Optional perf counters are enabled by defining COND_UNIT_PERF_EN.
module cond_unit_banked #(
  parameter  int NUM_BANKS = 2,
  parameter  int OUT_REG   = 1,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  input  logic [1:0]        FlagW,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic [BANK_W-1:0] BankSel,
  input  logic              SaveFlags,
  input  logic              RestoreFlags,
  output logic              CondEx,
  output logic [3:0]        Flags,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic [31:0]       ExecCount,
  output logic [31:0]       SquashCount
);

  logic [3:0] live   [NUM_BANKS];
  logic [3:0] shadow [NUM_BANKS];
  logic       bankOk, pass, pcsN, regN, memN;
  logic       n, z, c, v;

  assign bankOk = (32'(BankSel) < 32'(NUM_BANKS));

  always_comb begin
    Flags = 4'b0;
    if (bankOk) Flags = live[BankSel];
  end

  assign {n, z, c, v} = Flags;

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = (n == v);
      4'b1011: CondEx = (n != v);
      4'b1100: CondEx = ~z & (n == v);
      4'b1101: CondEx = z | (n != v);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
    if (!bankOk) CondEx = 1'b0;
  end

  assign pass = CondEx & ~Flush;
  assign pcsN = PCS & pass;
  assign regN = RegW & pass & ~NoWrite;
  assign memN = MemW & pass;

  // Save samples the pre-edge live value, so Save+Restore together swaps live and shadow.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        live[b]   <= 4'b0;
        shadow[b] <= 4'b0;
      end
    end else if (!Stall && bankOk) begin
      if (SaveFlags) shadow[BankSel] <= live[BankSel];
      if (RestoreFlags) live[BankSel] <= shadow[BankSel];
      else begin
        if (FlagW[1] && pass) live[BankSel][3:2] <= ALUFlags[3:2];
        if (FlagW[0] && pass) live[BankSel][1:0] <= ALUFlags[1:0];
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [2:0] oReg;
    always_ff @(posedge CLK) begin
      if (RESET)       oReg <= 3'b0;
      else if (!Stall) oReg <= {pcsN, regN, memN};
    end
    assign {PCSrc, RegWrite, MemWrite} = oReg;
  end else begin : g_ocomb
    assign {PCSrc, RegWrite, MemWrite} = {pcsN, regN, memN};
  end

`ifdef COND_UNIT_PERF_EN
  logic [31:0] execCnt, squashCnt;
  // Reserved condition code and invalid banks are not real instructions; skip them.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      execCnt   <= 32'b0;
      squashCnt <= 32'b0;
    end else if (!Stall && !Flush && bankOk && (Cond != 4'b1111)) begin
      if (CondEx) execCnt   <= execCnt + 32'd1;
      else        squashCnt <= squashCnt + 32'd1;
    end
  end
  assign ExecCount   = execCnt;
  assign SquashCount = squashCnt;
`else
  assign ExecCount   = 32'b0;
  assign SquashCount = 32'b0;
`endif

endmodule

// File: tb/tb_cond_unit_banked.sv
// Scoreboard bench for cond_unit_banked (NUM_BANKS=2, OUT_REG=1).
module tb_cond_unit_banked;
  logic        CLK = 1'b0;
  logic        RESET, Stall, Flush, PCS, RegW, MemW, NoWrite, SaveFlags, RestoreFlags;
  logic [1:0]  FlagW;
  logic [3:0]  Cond, ALUFlags;
  logic [0:0]  BankSel;
  logic        CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0]  Flags;
  logic [31:0] ExecCount, SquashCount;

  int nVec = 0;
  int nErr = 0;
  logic [3:0] mLive [2];
  logic [3:0] mShadow [2];
  logic [2:0] mOut;
  logic [2:0] sbq [$];
  logic       lastCx;

  always #5 CLK = ~CLK;

  cond_unit_banked #(.NUM_BANKS(2), .OUT_REG(1)) dut (
    .CLK(CLK), .RESET(RESET), .Stall(Stall), .Flush(Flush), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW), .Cond(Cond), .ALUFlags(ALUFlags),
    .BankSel(BankSel), .SaveFlags(SaveFlags), .RestoreFlags(RestoreFlags),
    .CondEx(CondEx), .Flags(Flags), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ExecCount(ExecCount), .SquashCount(SquashCount));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic condOk(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (c)
      4'h0: return fz;          4'h1: return !fz;
      4'h2: return fc;          4'h3: return !fc;
      4'h4: return fn;          4'h5: return !fn;
      4'h6: return fv;          4'h7: return !fv;
      4'h8: return fc && !fz;   4'h9: return !fc || fz;
      4'hA: return fn == fv;    4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return fz || (fn != fv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clr();
    Stall = 0; Flush = 0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    SaveFlags = 0; RestoreFlags = 0; FlagW = 2'b00; Cond = 4'hE; ALUFlags = 4'h0; BankSel = 1'b0;
  endtask

  task automatic mReset();
    for (int b = 0; b < 2; b++) begin mLive[b] = 4'h0; mShadow[b] = 4'h0; end
    mOut = 3'b0;
  endtask

  // Inputs are already applied; check comb outputs mid-cycle, then the registered ones after the edge.
  task automatic tick();
    logic e, p;
    logic [3:0] ol, os;
    #4;
    e = condOk(Cond, mLive[BankSel]);
    chk("condex", {31'b0, CondEx}, {31'b0, e});
    chk("flags", {28'b0, Flags}, {28'b0, mLive[BankSel]});
    lastCx = CondEx;
    p = e & ~Flush;
    if (!Stall) begin
      mOut = {PCS & p, RegW & p & ~NoWrite, MemW & p};
      ol = mLive[BankSel];
      os = mShadow[BankSel];
      if (SaveFlags) mShadow[BankSel] = ol;
      if (RestoreFlags) mLive[BankSel] = os;
      else begin
        if (FlagW[1] && p) mLive[BankSel][3:2] = ALUFlags[3:2];
        if (FlagW[0] && p) mLive[BankSel][1:0] = ALUFlags[1:0];
      end
    end
    sbq.push_back(mOut);
    @(posedge CLK); #1;
    chk("outs", {29'b0, PCSrc, RegWrite, MemWrite}, {29'b0, sbq.pop_front()});
  endtask

  task automatic outsIs(input string tag, input logic [2:0] exp);
    chk(tag, {29'b0, PCSrc, RegWrite, MemWrite}, {29'b0, exp});
  endtask

  initial begin
    clr(); RESET = 1; Stall = 1; mReset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_flags", {28'b0, Flags}, 32'h0);
    outsIs("rst_outs", 3'b000);
    RESET = 0; Stall = 0;

    clr(); RegW = 1; tick();
    chk("al_condex", {31'b0, lastCx}, 32'h1); outsIs("al_regw", 3'b010);

    clr(); FlagW = 2'b11; ALUFlags = 4'b0100; tick();
    chk("z_flags", {28'b0, Flags}, 32'h4);
    clr(); Cond = 4'h0; MemW = 1; tick();
    chk("eq_condex", {31'b0, lastCx}, 32'h1); outsIs("eq_memw", 3'b001);
    clr(); Cond = 4'h1; MemW = 1; tick();
    chk("ne_condex", {31'b0, lastCx}, 32'h0); outsIs("ne_memw", 3'b000);

    clr(); FlagW = 2'b11; ALUFlags = 4'b1000; tick();
    clr(); Cond = 4'hC; FlagW = 2'b11; ALUFlags = 4'b0100; tick();
    chk("gt_condex", {31'b0, lastCx}, 32'h0);
    chk("gt_flags", {28'b0, Flags}, 32'h8);
    clr(); Cond = 4'hD; tick(); chk("le_condex", {31'b0, lastCx}, 32'h1);
    clr(); Cond = 4'h8; tick(); chk("hi_condex", {31'b0, lastCx}, 32'h0);
    clr(); Cond = 4'h9; tick(); chk("ls_condex", {31'b0, lastCx}, 32'h1);

    clr(); FlagW = 2'b10; ALUFlags = 4'b0100; tick();
    chk("b0_flags", {28'b0, Flags}, 32'h4);
    clr(); BankSel = 1'b1; Cond = 4'h0; tick(); chk("b1_eq", {31'b0, lastCx}, 32'h0);
    clr(); Cond = 4'h0; tick(); chk("b0_eq", {31'b0, lastCx}, 32'h1);

    clr(); FlagW = 2'b11; ALUFlags = 4'b1001; tick();
    clr(); SaveFlags = 1; tick();
    clr(); FlagW = 2'b11; ALUFlags = 4'b0010; tick();
    clr(); SaveFlags = 1; RestoreFlags = 1; tick();
    chk("swap_live", {28'b0, Flags}, 32'h9);
    clr(); RestoreFlags = 1; tick();
    chk("swap_shadow", {28'b0, Flags}, 32'h2);
    clr(); RestoreFlags = 1; FlagW = 2'b11; ALUFlags = 4'b1111; tick();
    chk("rst_over_fw", {28'b0, Flags}, 32'h2);

    clr(); RegW = 1; tick();
    clr(); Stall = 1; PCS = 1; FlagW = 2'b11; ALUFlags = 4'b1111; tick();
    outsIs("stall_outs", 3'b010);
    chk("stall_flags", {28'b0, Flags}, 32'h2);
    clr(); Flush = 1; PCS = 1; FlagW = 2'b11; ALUFlags = 4'b1111; tick();
    outsIs("flush_outs", 3'b000);
    chk("flush_flags", {28'b0, Flags}, 32'h2);

    for (int i = 0; i < 80; i++) begin
      clr();
      Cond = 4'($urandom_range(0, 15));
      ALUFlags = 4'($urandom_range(0, 15));
      FlagW = 2'($urandom_range(0, 3));
      BankSel = 1'($urandom_range(0, 1));
      {PCS, RegW, MemW, NoWrite} = 4'($urandom_range(0, 15));
      Stall = ($urandom_range(0, 7) == 0);
      Flush = ($urandom_range(0, 5) == 0);
      SaveFlags = ($urandom_range(0, 7) == 0);
      RestoreFlags = ($urandom_range(0, 7) == 0);
      tick();
    end

    clr(); RESET = 1; mReset();
    @(posedge CLK); #1;
    RESET = 0;
    chk("exec_rst", ExecCount, 32'h0);
    chk("squash_rst", SquashCount, 32'h0);
`ifdef COND_UNIT_PERF_EN
    repeat (3) begin clr(); tick(); end
    repeat (2) begin clr(); Cond = 4'h0; tick(); end
    clr(); Flush = 1; tick();
    clr(); Cond = 4'hF; tick();
    clr(); Stall = 1; tick();
    chk("exec_cnt", ExecCount, 32'd3);
    chk("squash_cnt", SquashCount, 32'd2);
`else
    repeat (4) begin clr(); Cond = 4'($urandom_range(0, 14)); tick(); end
    chk("exec_tied", ExecCount, 32'h0);
    chk("squash_tied", SquashCount, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cond_unit_banked.md
Name: cond_unit_banked

Overview:
Parametrised conditional-execution unit for the EX stage of the pipelined ARM core. It evaluates the 4-bit condition field against NZCV flags held in NUM_BANKS selectable flag banks, each with a shadow (saved) copy. It gates PC, register and memory writes, and updates flags only when the instruction executes. Outputs are optionally registered into the MEM stage, and the unit supports stall and flush from the hazard unit.

Parameters:
NUM_BANKS, 2, number of independent NZCV flag banks (processor modes); must be >= 1.
BANK_W, $clog2(NUM_BANKS) with a minimum of 1, width of BankSel (localparam).
OUT_REG, 1, 1 = PCSrc/RegWrite/MemWrite registered (1-cycle latency); 0 = combinational.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  synchronous, active-high reset.
Stall  input  1  hold all state; no flag, shadow or output-register update.
Flush  input  1  squash current instruction (treated as CondEx=0 for all writes).
PCS  input  1  instruction writes PC.
RegW  input  1  instruction writes register file.
MemW  input  1  instruction writes memory.
NoWrite  input  1  compare-class op; suppress RegWrite.
FlagW  input  2  [1]=update N,Z; [0]=update C,V.
Cond  input  4  ARM condition field.
ALUFlags  input  4  {N,Z,C,V} from ALU this cycle.
BankSel  input  BANK_W  active flag bank.
SaveFlags  input  1  copy active bank live flags to its shadow.
RestoreFlags  input  1  copy active bank shadow to its live flags.
CondEx  output  1  condition passed (combinational, unflushed).
Flags  output  4  live {N,Z,C,V} of active bank.
PCSrc  output  1  gated PC write.
RegWrite  output  1  gated register write.
MemWrite  output  1  gated memory write.
ExecCount  output  32  executed-instruction counter (see Optional Feature).
SquashCount  output  32  condition-failed counter (see Optional Feature).

Behaviour:
- Reset: all live and shadow flags 0. Registered PCSrc/RegWrite/MemWrite 0. Counters 0.
- CondEx is combinational from the live flags of bank BankSel:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 reserved 0.
  - If BankSel >= NUM_BANKS, CondEx=0 and no state changes.
- Pass = CondEx & !Flush.
- Gated writes: PCSrc_n = PCS&Pass; RegWrite_n = RegW&Pass&!NoWrite; MemWrite_n = MemW&Pass.
  - OUT_REG=0: outputs equal the gated values combinationally.
  - OUT_REG=1: gated values are captured at the clock edge when !Stall and held when Stall.
  - A Flush on a non-stalled cycle loads 0.
- Flag update, at the clock edge, only when !Stall and the active bank only. Priority, highest first:
  1. RESET.
  2. Stall (hold).
  3. RestoreFlags (live <= shadow; overrides FlagW).
  4. FlagW gated by Pass: N,Z <= ALUFlags[3:2] if FlagW[1]; C,V <= ALUFlags[1:0] if FlagW[0].
- SaveFlags: shadow <= live value *before* this edge's update, when !Stall.
  - Save and Restore in the same cycle: shadow gets old live, live gets old shadow (swap).
- A new flag value is visible to CondEx on the cycle after the write edge. There is no same-cycle forwarding.
- Inactive banks never change.
- RESET asserted with Stall: reset wins.

Optional Feature:
- Macro COND_UNIT_PERF_EN.
- Defined: two 32-bit counters, updated on non-stalled, non-flushed cycles when Cond != 1111. ExecCount increments when CondEx=1; SquashCount increments when CondEx=0. Both wrap 0xFFFFFFFF -> 0, and both clear on RESET.
- Undefined: ExecCount and SquashCount are tied to 0 and no counter flops are generated.

Test Plan:
- Reset then AL RegW=1 -> Flags=0000, CondEx=1, RegWrite=1 one cycle later (OUT_REG=1).
- Cond=AL, FlagW=11, ALUFlags=0100; next cycle Cond=EQ MemW=1 -> CondEx=1, MemWrite=1; Cond=NE -> MemWrite=0.
- Flags NZCV=1000 with Cond=GT FlagW=11 ALUFlags=0100 -> CondEx=0, flags stay 1000. LE -> 1, HI -> 0, LS -> 1.
- Bank0: write Z=1; switch BankSel=1, Cond=EQ -> CondEx=0; back to bank 0 -> CondEx=1.
- Live 0010, shadow 1001, Save+Restore same cycle -> live 1001, shadow 0010. Restore+FlagW -> live = shadow.
- Stall with FlagW=11: flags and registered outputs held. Flush with PCS=1 Cond=AL -> PCSrc=0, flags unchanged.
- COND_UNIT_PERF_EN: 3 passing + 2 failing + 1 flushed -> ExecCount=3, SquashCount=2. Preset wrap test: 0xFFFFFFFF +1 -> 0.
